// File: rtl/issue_select_pkg.sv
// Shared issue-unit types: writeback reservation entry and latency encodings.
package issue_select_pkg;

  // Reservation entries carry tags up to this width; narrower tags are zero-extended.
  localparam int TAG_W_MAX = 16;
  localparam int LAT_W     = 2;

  localparam logic [LAT_W-1:0] LAT_NONE = 2'd0;
  localparam logic [LAT_W-1:0] LAT_1    = 2'd1;
  localparam logic [LAT_W-1:0] LAT_2    = 2'd2;
  localparam logic [LAT_W-1:0] LAT_3    = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic                 ldst_val;
    logic [TAG_W_MAX-1:0] pdst;
  } wb_stage_t;

  localparam wb_stage_t WB_STAGE_EMPTY = '0;

endpackage

// File: rtl/issue_select_prio_picker.sv
// Fixed-priority picker: one-hot of the lowest set request bit, zero if none.
module prio_picker #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/issue_select.sv
// Single-port issue select with writeback-port reservation and tag wakeup.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int PREG_SZ   = 7,
  parameter int MAX_LAT   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SLOTS-1:0]         io_slot_request,
  input  logic [NUM_SLOTS*PREG_SZ-1:0] io_slot_pdst,
  input  logic [NUM_SLOTS-1:0]         io_slot_ldst_val,
  input  logic [NUM_SLOTS*2-1:0]       io_slot_lat,
  input  logic                         io_fu_ready,
  input  logic                         io_kill,
  output logic [NUM_SLOTS-1:0]         io_slot_grant,
  output logic                         io_iss_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] io_iss_slot_idx,
  output logic [PREG_SZ-1:0]           io_iss_pdst,
  output logic                         io_wakeup_valid,
  output logic [PREG_SZ-1:0]           io_wakeup_pdst
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] grant;

  logic                 grant_any;
  logic [IDX_W-1:0]     grant_idx;
  logic [PREG_SZ-1:0]   grant_pdst;
  logic [LAT_W-1:0]     grant_lat;
  logic                 grant_ldst;
  wb_stage_t            new_entry;

  wb_stage_t stage_q [1:MAX_LAT];
  wb_stage_t stage_d [1:MAX_LAT];

  logic                 iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0]     iss_idx_q,   iss_idx_d;
  logic [PREG_SZ-1:0]   iss_pdst_q,  iss_pdst_d;

  // A slot whose result would land on the same cycle as an already reserved
  // writeback (entry sitting one stage above its latency) must wait.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [LAT_W-1:0] lat;
      logic             conflict;

      assign lat = io_slot_lat[gi*LAT_W +: LAT_W];

      always_comb begin
        conflict = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
          if (lat == LAT_W'(k) && stage_q[k+1].valid) begin
            conflict = 1'b1;
          end
        end
      end

      assign eligible[gi] = io_slot_request[gi] & io_fu_ready & ~io_kill
                            & ~reset & ~conflict;
    end
  endgenerate

  prio_picker #(
    .WIDTH (NUM_SLOTS)
  ) u_picker (
    .req   (eligible),
    .grant (grant)
  );

  assign io_slot_grant = grant;

  always_comb begin
    grant_any  = |grant;
    grant_idx  = '0;
    grant_pdst = '0;
    grant_lat  = LAT_NONE;
    grant_ldst = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) begin
        grant_idx  = IDX_W'(i);
        grant_pdst = io_slot_pdst[i*PREG_SZ +: PREG_SZ];
        grant_lat  = io_slot_lat[i*LAT_W +: LAT_W];
        grant_ldst = io_slot_ldst_val[i];
      end
    end
  end

  // Reservation pipeline: shift toward stage 1, granted uop overrides its stage.
  always_comb begin
    new_entry          = WB_STAGE_EMPTY;
    new_entry.valid    = 1'b1;
    new_entry.ldst_val = grant_ldst;
    new_entry.pdst     = TAG_W_MAX'(grant_pdst);

    for (int k = 1; k < MAX_LAT; k++) begin
      stage_d[k] = stage_q[k+1];
    end
    stage_d[MAX_LAT] = WB_STAGE_EMPTY;

    for (int k = 1; k <= MAX_LAT; k++) begin
      if (grant_any && grant_lat == LAT_W'(k)) begin
        stage_d[k] = new_entry;
      end
    end

    if (io_kill) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        stage_d[k] = WB_STAGE_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (reset) begin
        stage_q[k] <= WB_STAGE_EMPTY;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Issue report; kill already forces a zero grant, so it clears naturally.
  always_comb begin
    iss_valid_d = grant_any;
    iss_idx_d   = grant_idx;
    iss_pdst_d  = grant_pdst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      iss_pdst_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      iss_pdst_q  <= iss_pdst_d;
    end
  end

  assign io_iss_valid    = iss_valid_q;
  assign io_iss_slot_idx = iss_idx_q;
  assign io_iss_pdst     = iss_pdst_q;

  assign io_wakeup_valid = stage_q[1].valid & stage_q[1].ldst_val;
  assign io_wakeup_pdst  = PREG_SZ'(stage_q[1].pdst);

endmodule
